// File: rtl/fp16_sub_seq.sv
// rtl/fp16_sub_seq.sv - sequential binary16 subtractor (a - b), truncating, no subnormal/inf/nan handling.
// Overflow result selected by FP16_SUB_SATURATE_EN (max finite when defined, infinity otherwise).
module fp16_sub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] float_a,
  input  logic [15:0] float_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t             state, state_nx;
  logic               sign_a, sign_b;
  logic [4:0]         exp_a, exp_b;
  logic [10:0]        frac_a, frac_b;
  logic               res_sign;
  logic signed [6:0]  res_exp;
  logic [10:0]        res_frac;
  logic [15:0]        diff_q;

  logic               a_zero, b_zero, special;
  logic [15:0]        special_diff;
  logic [4:0]         shift;
  logic [10:0]        al_a, al_b;
  logic [4:0]         al_exp;
  logic [11:0]        sum;
  logic               add_sign;
  logic [10:0]        add_frac;
  logic signed [6:0]  add_exp;
  logic               add_done;
  logic [10:0]        norm_frac;
  logic signed [6:0]  norm_exp;

  function automatic logic [15:0] pack(input logic s, input logic signed [6:0] e,
                                       input logic [10:0] f);
    if (f == 11'd0 || e < 7'sd1)
      pack = 16'h0000;
    else if (e >= 7'sd31)
`ifdef FP16_SUB_SATURATE_EN
      pack = {s, 5'h1E, 10'h3FF};
`else
      pack = {s, 5'h1F, 10'h000};
`endif
    else
      pack = {s, e[4:0], f[9:0]};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;

  always_comb begin
    a_zero       = (float_a[14:0] == 15'd0);
    b_zero       = (float_b[14:0] == 15'd0);
    special      = a_zero || b_zero || (float_a == float_b);
    special_diff = a_zero ? {~float_b[15], float_b[14:0]} :
                   b_zero ? float_a : 16'h0000;

    // Align: the smaller operand loses everything shifted past bit 0.
    al_a   = frac_a;
    al_b   = frac_b;
    al_exp = exp_a;
    shift  = 5'd0;
    if (exp_a >= exp_b) begin
      shift  = exp_a - exp_b;
      al_b   = (shift >= 5'd11) ? 11'd0 : (frac_b >> shift);
    end else begin
      shift  = exp_b - exp_a;
      al_a   = (shift >= 5'd11) ? 11'd0 : (frac_a >> shift);
      al_exp = exp_b;
    end

    // Magnitude add/subtract; sign_b already holds the inverted subtrahend sign.
    if (sign_a == sign_b) begin
      sum      = {1'b0, frac_a} + {1'b0, frac_b};
      add_sign = sign_a;
    end else if (frac_a >= frac_b) begin
      sum      = {1'b0, frac_a} - {1'b0, frac_b};
      add_sign = sign_a;
    end else begin
      sum      = {1'b0, frac_b} - {1'b0, frac_a};
      add_sign = sign_b;
    end
    if (sum[11]) begin
      add_frac = sum[11:1];
      add_exp  = res_exp + 7'sd1;
    end else begin
      add_frac = sum[10:0];
      add_exp  = res_exp;
    end
    add_done = sum[11] || add_frac[10] || (add_frac == 11'd0);

    norm_frac = {res_frac[9:0], 1'b0};
    norm_exp  = res_exp - 7'sd1;

    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = special ? DONE : ALIGN;
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = add_done ? DONE : NORM;
      NORM:    if (norm_frac[10]) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      exp_a    <= 5'd0;
      exp_b    <= 5'd0;
      frac_a   <= 11'd0;
      frac_b   <= 11'd0;
      res_sign <= 1'b0;
      res_exp  <= 7'sd0;
      res_frac <= 11'd0;
      diff_q   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_a <= float_a[15];
            sign_b <= ~float_b[15];
            exp_a  <= float_a[14:10];
            exp_b  <= float_b[14:10];
            frac_a <= {1'b1, float_a[9:0]};
            frac_b <= {1'b1, float_b[9:0]};
            if (special) diff_q <= special_diff;
          end
        end
        ALIGN: begin
          frac_a  <= al_a;
          frac_b  <= al_b;
          res_exp <= signed'({2'b00, al_exp});
        end
        ADD: begin
          res_sign <= add_sign;
          res_frac <= add_frac;
          res_exp  <= add_exp;
          if (add_done) diff_q <= pack(add_sign, add_exp, add_frac);
        end
        NORM: begin
          res_frac <= norm_frac;
          res_exp  <= norm_exp;
          if (norm_frac[10]) diff_q <= pack(res_sign, norm_exp, norm_frac);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_sub_seq.sv
// tb/tb_fp16_sub_seq.sv - directed vector bench for fp16_sub_seq.
module tb_fp16_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] float_a = 16'h0;
  logic [15:0] float_b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;

  int n_vec  = 0;
  int n_fail = 0;

`ifdef FP16_SUB_SATURATE_EN
  localparam logic [15:0] OVF_POS = 16'h7BFF;
`else
  localparam logic [15:0] OVF_POS = 16'h7C00;
`endif

  fp16_sub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .float_a(float_a), .float_b(float_b), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Accepts one operand pair from IDLE and waits for out_valid; lat counts cycles after the accept edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] d, output int lat);
    float_a  = a;
    float_b  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    d = diff;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    int          lat;

    vecs[0]  = '{16'h3C00, 16'h3800, 16'h3800, 4};
    vecs[1]  = '{16'h3C00, 16'hBC00, 16'h4000, 3};
    vecs[2]  = '{16'h4000, 16'h4000, 16'h0000, 1};
    vecs[3]  = '{16'h0000, 16'h3C00, 16'hBC00, 1};
    vecs[4]  = '{16'h3555, 16'h0000, 16'h3555, 1};
    vecs[5]  = '{16'h7BFF, 16'hFBFF, OVF_POS,  3};
    vecs[6]  = '{16'h3C00, 16'h3BFF, 16'h1400, 13};
    vecs[7]  = '{16'h3800, 16'h3C00, 16'hB800, 4};
    vecs[8]  = '{16'h4200, 16'h3C00, 16'h4000, 3};
    vecs[9]  = '{16'h6400, 16'h3C00, 16'h63FE, 4};
    vecs[10] = '{16'h6800, 16'h3C00, 16'h6800, 3};
    vecs[11] = '{16'h0401, 16'h0400, 16'h0000, 13};
    vecs[12] = '{16'hBC00, 16'h3C00, 16'hC000, 3};
    vecs[13] = '{16'h8000, 16'h3800, 16'hB800, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_diff", {16'd0, diff}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, d, lat);
      chk($sformatf("vec%0d_diff", i), {16'd0, d}, {16'd0, vecs[i].d});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      release_result();
    end

    // Result held under back-pressure; a pending operand must not slip in.
    run_op(16'h3C00, 16'h3800, d, lat);
    chk("hold_first_diff", {16'd0, d}, 32'h3800);
    float_a  = 16'h4000;
    float_b  = 16'h3C00;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_diff", i), {16'd0, diff}, 32'h3800);
      chk($sformatf("hold%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("deliver_out_valid", {31'd0, out_valid}, 32'd0);
    chk("deliver_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("no_accept_out_valid", {31'd0, out_valid}, 32'd0);
    chk("no_accept_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a long normalisation.
    float_a  = 16'h3C00;
    float_b  = 16'h3BFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("norm_busy_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_diff", {16'd0, diff}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(16'h3C00, 16'h3800, d, lat);
    chk("after_rst_diff", {16'd0, d}, 32'h3800);
    chk("after_rst_latency", lat, 4);
    release_result();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_sub_seq.md
FP16_SUB_SEQ -- requirements
Module: fp16_sub_seq

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port in_valid  input  1  operand pair valid.
REQ-004 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-005 SHALL have port float_a  input  16  minuend, IEEE binary16 {sign,exp[4:0],man[9:0]}.
REQ-006 SHALL have port float_b  input  16  subtrahend, same format.
REQ-007 SHALL have port out_valid  output  1  diff holds a result.
REQ-008 SHALL have port out_ready  input  1  consumer accepts result.
REQ-009 SHALL have port diff  output  16  result a-b, binary16.

Function
REQ-010 SHALL accept operands on a rising edge with in_valid&&in_ready; in_ready SHALL be 1 only in IDLE.
REQ-011 SHALL hold states IDLE, ALIGN, ADD, NORM, DONE.
REQ-012 SHALL treat an operand as zero when bits[14:0]==0; every other operand is normal with hidden bit 1 (11-bit fraction); exp 0 and 31 get no special handling.
REQ-013 Special cases SHALL go IDLE->DONE on the accepting edge: a zero -> diff=b with sign inverted; b zero -> diff=a; a[14:0]==b[14:0] with a[15]==b[15] -> diff=0x0000.
REQ-014 Otherwise IDLE->ALIGN on accept; b's sign is inverted internally; ALIGN SHALL right-shift the smaller-exponent fraction by the exponent difference, discarding shifted-out bits; difference >=11 gives fraction 0; result exponent = larger exponent.
REQ-015 ADD (one cycle) SHALL add the fractions if effective signs match, else subtract smaller from larger, sign = sign of larger aligned magnitude; on carry out of bit 10, shift right 1 (truncate) and increment exponent, then ->DONE; otherwise ->NORM.
REQ-016 NORM SHALL left-shift the fraction by one bit and decrement the exponent per cycle while fraction[10]==0 and fraction!=0; then ->DONE.
REQ-017 Result with zero fraction, or exponent <1 after normalisation, SHALL be diff=0x0000.
REQ-018 Result exponent >=31 SHALL be overflow, handled per REQ-025.
REQ-019 Otherwise diff SHALL be {sign, exp[4:0], fraction[9:0]}; no rounding.
REQ-020 Latency: special case, out_valid 1 cycle after accept; normal, 3+k cycles after accept, k = NORM shifts (0..10).
REQ-021 In DONE, out_valid=1 and diff SHALL stay stable until the edge where out_ready=1, then ->IDLE; in_ready SHALL not rise in that same cycle (no accept/deliver overlap).
REQ-022 Internal exponent SHALL be at least 7-bit signed so decrements below 0 and carry above 31 are detectable.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, in_ready=1 (while low and after release), out_valid=0, diff=0x0000, discarding any in-flight operation.
REQ-024 First accept after release SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-025 Macro FP16_SUB_SATURATE_EN: defined -> overflow yields {sign,0x1E,0x3FF} (max finite); undefined -> overflow yields {sign,0x1F,0x000} (infinity).

Verification
REQ-026 a=0x3C00, b=0x3800 -> diff=0x3800, out_valid 4 cycles after accept (k=1).
REQ-027 a=0x3C00, b=0xBC00 -> diff=0x4000 via carry path, out_valid 3 cycles after accept; a=0x4000, b=0x4000 -> 0x0000 after 1 cycle.
REQ-028 a=0x0000, b=0x3C00 -> diff=0xBC00 after 1 cycle; a=0x3555, b=0x0000 -> 0x3555.
REQ-029 a=0x7BFF, b=0xFBFF -> 0x7BFF with FP16_SUB_SATURATE_EN, 0x7C00 without.
REQ-030 out_ready held low 5 cycles in DONE -> diff stable, out_valid=1, in_ready=0 throughout; in_valid during that time not accepted.
REQ-031 rst_n pulsed low during NORM (a=0x3C00, b=0x3BFF) -> out_valid=0, in_ready=1 immediately; next operation correct.
